// File: rtl/data_mem_unit_pkg.sv
// Shared types and helpers for the data-memory stage of the single-cycle core.
package data_mem_unit_pkg;

    // Access sequencing states of the data-memory controller.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    // Wide enough for the largest supported wait-state count (15).
    localparam int CNT_W = 4;

    // Number of word-index bits needed to address a DEPTH-word array.
    function automatic int word_index_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// DEPTH x 32 storage with one shared address port: synchronous write,
// combinational read. The read value is registered by the controller.
module mem_word_array
    import data_mem_unit_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = word_index_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    // Storage is deliberately not reset; contents are undefined until written.
    logic [31:0] mem_q [DEPTH];

    // Store the write word on the rising edge when a write access completes.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/data_mem_unit.sv
// Data-memory stage: word-addressed RAM with configurable wait states.
// Stalls the core until each legal access completes and raises a sticky
// error flag for misaligned or read+write-conflicting requests.
//
// Handshake: MemRead/MemWrite act as a request held for the whole
// instruction; stall is the inverse of ready. The core may advance only on
// an edge where stall is 0, and the access completes on the edge that moves
// the FSM into DONE. The request is expected to stay stable until the core
// advances out of DONE.
module data_mem_unit
    import data_mem_unit_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] memAddress,
    input  logic [31:0] writeData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] readData,
    output logic        stall,
    output logic        memError,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    localparam int             IDX_W   = word_index_width(DEPTH);
    localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WAIT_STATES);
    localparam bit             NO_WAIT = (WAIT_STATES == 0);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      read_data_q, read_data_d;
    logic             mem_error_q, mem_error_d;

    logic             req;
    logic             aligned;
    logic             conflict;
    logic             legal;
    logic             access;
    logic             mem_we;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      mem_rdata;
    logic             unused_addr_bits;

    // Request legality and word index; upper address bits are dropped so
    // accesses wrap modulo DEPTH words.
    assign req              = MemRead | MemWrite;
    assign aligned          = (memAddress[1:0] == 2'b00);
    assign conflict         = MemRead & MemWrite;
    assign legal            = req & aligned & ~conflict;
    assign word_idx         = memAddress[IDX_W+1:2];
    assign unused_addr_bits = ^memAddress[31:IDX_W+2];

    // Next-state, wait counter, completion strobe and error flag.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        access      = 1'b0;
        mem_error_d = mem_error_q;
        case (state_q)
            IDLE: begin
                if (legal) begin
                    if (NO_WAIT) begin
                        access  = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = WS_LOAD;
                        state_d = WAIT;
                    end
                end else if (req) begin
                    // Illegal request: flag it, touch nothing, let the core proceed.
                    mem_error_d = 1'b1;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    access  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Unconditional: the core advances on this same edge.
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The completing edge latches whatever request is present at that edge.
    assign mem_we      = access & MemWrite;
    assign read_data_d = (access & MemRead) ? mem_rdata : read_data_q;

    // Controller state registers; reset aborts any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            read_data_q <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
            mem_error_q <= mem_error_d;
        end
    end

    mem_word_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (word_idx),
        .wdata (writeData),
        .rdata (mem_rdata)
    );

    // Stall covers the request cycle and every wait cycle, never DONE,
    // and is held low while reset is asserted.
    assign stall     = ~rst & (((state_q == IDLE) & legal) | (state_q == WAIT));
    assign busy      = (state_q != IDLE);
    assign readData  = read_data_q;
    assign memError  = mem_error_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: one instance with 2 wait states (unit 0)
// and one with no wait states (unit 1), sharing clock and reset.
module tb_data_mem_unit;

    logic        clk;
    logic        rst;

    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        a_rd, a_wr, a_stall, a_err, a_busy;
    logic [1:0]  a_state;

    logic [31:0] b_addr, b_wdata, b_rdata;
    logic        b_rd, b_wr, b_stall, b_err, b_busy;
    logic [1:0]  b_state;

    int checks   = 0;
    int failures = 0;

    data_mem_unit #(.DEPTH(256), .WAIT_STATES(2)) dut_ws2 (
        .clk        (clk),
        .rst        (rst),
        .memAddress (a_addr),
        .writeData  (a_wdata),
        .MemRead    (a_rd),
        .MemWrite   (a_wr),
        .readData   (a_rdata),
        .stall      (a_stall),
        .memError   (a_err),
        .busy       (a_busy),
        .state_dbg  (a_state)
    );

    data_mem_unit #(.DEPTH(256), .WAIT_STATES(0)) dut_ws0 (
        .clk        (clk),
        .rst        (rst),
        .memAddress (b_addr),
        .writeData  (b_wdata),
        .MemRead    (b_rd),
        .MemWrite   (b_wr),
        .readData   (b_rdata),
        .stall      (b_stall),
        .memError   (b_err),
        .busy       (b_busy),
        .state_dbg  (b_state)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int unit, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data);
        if (unit == 0) begin
            a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = data;
        end else begin
            b_rd = rd; b_wr = wr; b_addr = addr; b_wdata = data;
        end
    endtask

    // Issues one request from just after a rising edge, holds it until the
    // edge that leaves DONE, then drops it. Reports cycles spent (request
    // cycle through DONE), cycles with stall high, and readData seen in DONE.
    task automatic run_access(input int unit, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] data,
                              output int stalls, output int cycles,
                              output logic [31:0] rdata_done);
        bit found;
        found      = 1'b0;
        stalls     = 0;
        cycles     = 0;
        rdata_done = 32'hxxxx_xxxx;
        drive(unit, rd, wr, addr, data);
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            cycles++;
            if ((unit == 0) ? a_stall : b_stall) stalls++;
            if (((unit == 0) ? a_state : b_state) == 2'd2) begin
                found      = 1'b1;
                rdata_done = (unit == 0) ? a_rdata : b_rdata;
            end
            @(posedge clk);
            #1;
        end
        drive(unit, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    int          st, cyc;
    logic [31:0] rdv;

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset values
        check("rst_stall",   32'(a_stall), 32'd0);
        check("rst_busy",    32'(a_busy),  32'd0);
        check("rst_rdata",   a_rdata,      32'h0);
        check("rst_err",     32'(a_err),   32'd0);
        check("rst_state",   32'(a_state), 32'd0);
        check("rst_rdata_b", b_rdata,      32'h0);
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        check("rst_stall_gated", 32'(a_stall), 32'd0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Store then load 0x10 with two wait states
        run_access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, st, cyc, rdv);
        check("st10_stalls", 32'(st),  32'd3);
        check("st10_cycles", 32'(cyc), 32'd4);
        check("st10_rdata_kept", a_rdata, 32'h0);
        run_access(0, 1'b1, 1'b0, 32'h10, 32'h0, st, cyc, rdv);
        check("ld10_stalls", 32'(st),  32'd3);
        check("ld10_cycles", 32'(cyc), 32'd4);
        check("ld10_rdata",  rdv,      32'hDEADBEEF);
        check("ld10_hold",   a_rdata,  32'hDEADBEEF);

        // Misaligned load
        drive(0, 1'b1, 1'b0, 32'h12, 32'h0);
        @(negedge clk);
        check("mis_stall",     32'(a_stall), 32'd0);
        check("mis_err_early", 32'(a_err),   32'd0);
        @(posedge clk);
        #1;
        check("mis_err",   32'(a_err),   32'd1);
        check("mis_state", 32'(a_state), 32'd0);
        check("mis_rdata", a_rdata,      32'hDEADBEEF);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        run_access(0, 1'b1, 1'b0, 32'h10, 32'h0, st, cyc, rdv);
        check("mis_mem_intact", rdv, 32'hDEADBEEF);

        // Read+write conflict at 0x20; clear the sticky flag first
        run_access(0, 1'b0, 1'b1, 32'h20, 32'h12345678, st, cyc, rdv);
        rst = 1'b1;
        #1;
        check("err_cleared", 32'(a_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 1'b1, 1'b1, 32'h20, 32'hBAD0BAD0);
        @(negedge clk);
        check("conf_stall", 32'(a_stall), 32'd0);
        @(posedge clk);
        #1;
        check("conf_err",   32'(a_err),   32'd1);
        check("conf_state", 32'(a_state), 32'd0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        run_access(0, 1'b1, 1'b0, 32'h20, 32'h0, st, cyc, rdv);
        check("conf_no_write", rdv, 32'h12345678);
        check("err_sticky", 32'(a_err), 32'd1);

        // Address wrap: 0x400 aliases word 0 in a 256-word array
        run_access(0, 1'b0, 1'b1, 32'h400, 32'h11111111, st, cyc, rdv);
        run_access(0, 1'b1, 1'b0, 32'h000, 32'h0, st, cyc, rdv);
        check("wrap_rdata", rdv, 32'h11111111);

        // Zero wait states: back-to-back loads
        run_access(1, 1'b0, 1'b1, 32'h0, 32'hAAAA0000, st, cyc, rdv);
        check("ws0_st_cycles", 32'(cyc), 32'd2);
        run_access(1, 1'b0, 1'b1, 32'h4, 32'h0000BBBB, st, cyc, rdv);
        run_access(1, 1'b1, 1'b0, 32'h0, 32'h0, st, cyc, rdv);
        check("ws0_ld0_stalls", 32'(st),  32'd1);
        check("ws0_ld0_cycles", 32'(cyc), 32'd2);
        check("ws0_ld0_rdata",  rdv,      32'hAAAA0000);
        run_access(1, 1'b1, 1'b0, 32'h4, 32'h0, st, cyc, rdv);
        check("ws0_ld4_stalls", 32'(st),  32'd1);
        check("ws0_ld4_cycles", 32'(cyc), 32'd2);
        check("ws0_ld4_rdata",  rdv,      32'h0000BBBB);
        check("ws0_err",        32'(b_err), 32'd0);

        // Reset during the wait of a store to 0x8
        run_access(0, 1'b0, 1'b1, 32'h8, 32'h5555AAAA, st, cyc, rdv);
        drive(0, 1'b0, 1'b1, 32'h8, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rmid_in_wait", 32'(a_state), 32'd1);
        check("rmid_stall_w", 32'(a_stall), 32'd1);
        rst = 1'b1;
        #1;
        check("rmid_state", 32'(a_state), 32'd0);
        check("rmid_stall", 32'(a_stall), 32'd0);
        check("rmid_busy",  32'(a_busy),  32'd0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_access(0, 1'b1, 1'b0, 32'h8, 32'h0, st, cyc, rdv);
        check("rmid_no_write", rdv, 32'h5555AAAA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net against an unexpected hang.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
